// File: rtl/rx_tlp_pkg.sv
// Shared types, default parameters and helpers for the RX TLP scheduler.
package rx_tlp_pkg;

    localparam int ADDR_W_DEF      = 11;
    localparam int TLP_QW_DEF      = 16;
    localparam int PAGE_LOG2_DEF   = 18;
    localparam int PAGE_HDR_QW_DEF = 16;
    localparam int TO_W_DEF        = 28;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        REQ,
        ACK_LOW,
        CLOSE,
        FLUSH,
        CHANGE,
        CHG_WAIT,
        CHG_LOW
    } state_t;

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Upper bits beyond the real pointer width must be zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchroniser for a bus of independently sampled (Gray or level) bits.
module cdc_sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk156,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_tlp_scheduler.sv
// Schedules full-payload TLPs, partial flushes and huge-page changes from RX buffer
// occupancy, with a synchronised TX read pointer and 4-phase request/ack handshakes.
module rx_tlp_scheduler
    import rx_tlp_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TLP_QW      = TLP_QW_DEF,
    parameter int PAGE_LOG2   = PAGE_LOG2_DEF,
    parameter int PAGE_HDR_QW = PAGE_HDR_QW_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic                      clk156,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [TO_W-1:0]           timeout_cycles,
    input  logic [ADDR_W-1:0]         commited_wr_address,
    input  logic [ADDR_W-1:0]         commited_rd_address_gray,
    output logic                      trigger_tlp,
    input  logic                      trigger_tlp_ack,
    output logic                      change_huge_page,
    output logic                      send_last_tlp_change_huge_page,
    input  logic                      change_huge_page_ack,
    output logic [clog2w(TLP_QW):0]   qwords_to_send,
    output logic [PAGE_LOG2:0]        page_qword_offset,
    output logic [31:0]               tlp_count,
    output logic [31:0]               page_count
);

    localparam int QW_LOG2 = clog2w(TLP_QW);
    localparam int OCC_W   = ADDR_W - 1;
    localparam int NT_W    = OCC_W - QW_LOG2;
    localparam int OFF_W   = PAGE_LOG2 + 1;
    localparam int SUM_W   = ((OFF_W > OCC_W) ? OFF_W : OCC_W) + 1;
    localparam logic [QW_LOG2:0] QW_FULL = (QW_LOG2 + 1)'(TLP_QW);
    localparam logic [OFF_W-1:0] OFF_HDR = OFF_W'(PAGE_HDR_QW);
    localparam logic [OFF_W-1:0] OFF_TLP = OFF_W'(TLP_QW);

    logic [ADDR_W-1:0]  rd_gray_s, rd_bin;
    logic               tlp_ack_s, chg_ack_s, timeout;
    logic [OCC_W-1:0]   occ;
    logic [TO_W-1:0]    to_cnt;
    logic [SUM_W-1:0]   look_sum;
    state_t             state, state_d;
    logic [NT_W-1:0]    n_tlp, n_tlp_d, sent, sent_d;
    logic [QW_LOG2-1:0] rem_new, rem_new_d, rem, rem_d;
    logic               page_ovf, page_ovf_d, dirty, dirty_d;
    logic               trig_d, chg_d, last_d;
    logic [QW_LOG2:0]   qw_d;
    logic [OFF_W-1:0]   offset_d;
    logic [31:0]        tlp_cnt_d, page_cnt_d;

    cdc_sync_2ff #(.W(ADDR_W)) u_sync_rd  (.clk156(clk156), .reset_n(reset_n), .d(commited_rd_address_gray), .q(rd_gray_s));
    cdc_sync_2ff #(.W(1))      u_sync_tlp (.clk156(clk156), .reset_n(reset_n), .d(trigger_tlp_ack),          .q(tlp_ack_s));
    cdc_sync_2ff #(.W(1))      u_sync_chg (.clk156(clk156), .reset_n(reset_n), .d(change_huge_page_ack),     .q(chg_ack_s));

    assign rd_bin  = ADDR_W'(gray2bin(32'(rd_gray_s)));
    assign timeout = (timeout_cycles != '0) && (to_cnt == timeout_cycles);
    // Widened so an offset+occupancy carry past the page bit is never truncated away.
    assign look_sum = SUM_W'(page_qword_offset) + SUM_W'(occ);

    always_comb begin
        state_d    = state;
        n_tlp_d    = n_tlp;
        rem_new_d  = rem_new;
        page_ovf_d = page_ovf;
        rem_d      = rem;
        dirty_d    = dirty;
        sent_d     = sent;
        trig_d     = trigger_tlp;
        chg_d      = change_huge_page;
        last_d     = send_last_tlp_change_huge_page;
        qw_d       = qwords_to_send;
        offset_d   = page_qword_offset;
        tlp_cnt_d  = tlp_count;
        page_cnt_d = page_count;
        case (state)
            IDLE: begin
                n_tlp_d    = occ[OCC_W-1:QW_LOG2];
                rem_new_d  = occ[QW_LOG2-1:0];
                page_ovf_d = |(look_sum >> PAGE_LOG2);
                if (enable && (occ[OCC_W-1:QW_LOG2] != '0)) begin
                    state_d = CHECK;
                    qw_d    = QW_FULL;
                end else if (enable && timeout && dirty) begin
                    state_d = CLOSE;
                end else if (enable && timeout && (occ != '0)) begin
                    state_d = FLUSH;
                    qw_d    = occ[QW_LOG2:0];
                end
            end
            CHECK: begin
                if (page_ovf) begin
                    if (rem == '0) begin
                        state_d = CHANGE;
                    end else begin
                        state_d = FLUSH;
                        qw_d    = {1'b0, rem};
                    end
                end else begin
                    rem_d   = rem_new;
                    dirty_d = 1'b1;
                    sent_d  = '0;
                    trig_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tlp_ack_s) begin
                    trig_d    = 1'b0;
                    offset_d  = page_qword_offset + OFF_TLP;
                    sent_d    = sent + NT_W'(1);
                    tlp_cnt_d = tlp_count + 32'd1;
                    state_d   = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (!tlp_ack_s) begin
                    if (sent < n_tlp) begin
                        trig_d  = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLOSE: begin
                if (rem == '0) begin
                    state_d = CHANGE;
                end else begin
                    state_d = FLUSH;
                    qw_d    = {1'b0, rem};
                end
            end
            FLUSH: begin
                last_d  = 1'b1;
                state_d = CHG_WAIT;
            end
            CHANGE: begin
                chg_d   = 1'b1;
                state_d = CHG_WAIT;
            end
            CHG_WAIT: begin
                if (chg_ack_s) begin
                    chg_d      = 1'b0;
                    last_d     = 1'b0;
                    offset_d   = OFF_HDR;
                    rem_d      = '0;
                    dirty_d    = 1'b0;
                    page_cnt_d = page_count + 32'd1;
                    state_d    = CHG_LOW;
                end
            end
            CHG_LOW: begin
                if (!chg_ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            state                          <= IDLE;
            occ                            <= '0;
            to_cnt                         <= '0;
            n_tlp                          <= '0;
            rem_new                        <= '0;
            page_ovf                       <= 1'b0;
            rem                            <= '0;
            dirty                          <= 1'b0;
            sent                           <= '0;
            trigger_tlp                    <= 1'b0;
            change_huge_page               <= 1'b0;
            send_last_tlp_change_huge_page <= 1'b0;
            qwords_to_send                 <= QW_FULL;
            page_qword_offset              <= OFF_HDR;
            tlp_count                      <= '0;
            page_count                     <= '0;
        end else begin
            state                          <= state_d;
            occ                            <= OCC_W'(commited_wr_address - rd_bin);
            to_cnt                         <= ((state != IDLE) || timeout) ? '0 : to_cnt + TO_W'(1);
            n_tlp                          <= n_tlp_d;
            rem_new                        <= rem_new_d;
            page_ovf                       <= page_ovf_d;
            rem                            <= rem_d;
            dirty                          <= dirty_d;
            sent                           <= sent_d;
            trigger_tlp                    <= trig_d;
            change_huge_page               <= chg_d;
            send_last_tlp_change_huge_page <= last_d;
            qwords_to_send                 <= qw_d;
            page_qword_offset              <= offset_d;
            tlp_count                      <= tlp_cnt_d;
            page_count                     <= page_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_tlp_scheduler.sv
// Directed bench for rx_tlp_scheduler; a 256-QW page makes the page-overflow path reachable.
`timescale 1ns/1ps
module tb_rx_tlp_scheduler;

    localparam int ADDR_W      = 11;
    localparam int TLP_QW      = 16;
    localparam int PAGE_LOG2   = 8;
    localparam int PAGE_HDR_QW = 16;
    localparam int TO_W        = 28;

    logic                 clk156 = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 enable = 1'b0;
    logic [TO_W-1:0]      timeout_cycles = '0;
    logic [ADDR_W-1:0]    wr_ptr = '0;
    logic [ADDR_W-1:0]    rd_ptr = '0;
    logic [ADDR_W-1:0]    rd_gray;
    logic                 trigger_tlp;
    logic                 trigger_tlp_ack = 1'b0;
    logic                 change_huge_page;
    logic                 send_last;
    logic                 change_huge_page_ack = 1'b0;
    logic [4:0]           qwords_to_send;
    logic [PAGE_LOG2:0]   page_qword_offset;
    logic [31:0]          tlp_count;
    logic [31:0]          page_count;

    int checks = 0;
    int errors = 0;

    assign rd_gray = rd_ptr ^ (rd_ptr >> 1);

    always #3.2 clk156 = ~clk156;

    rx_tlp_scheduler #(
        .ADDR_W(ADDR_W), .TLP_QW(TLP_QW), .PAGE_LOG2(PAGE_LOG2),
        .PAGE_HDR_QW(PAGE_HDR_QW), .TO_W(TO_W)
    ) dut (
        .clk156(clk156),
        .reset_n(reset_n),
        .enable(enable),
        .timeout_cycles(timeout_cycles),
        .commited_wr_address(wr_ptr),
        .commited_rd_address_gray(rd_gray),
        .trigger_tlp(trigger_tlp),
        .trigger_tlp_ack(trigger_tlp_ack),
        .change_huge_page(change_huge_page),
        .send_last_tlp_change_huge_page(send_last),
        .change_huge_page_ack(change_huge_page_ack),
        .qwords_to_send(qwords_to_send),
        .page_qword_offset(page_qword_offset),
        .tlp_count(tlp_count),
        .page_count(page_count)
    );

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return trigger_tlp;
            1:       return change_huge_page;
            default: return send_last;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic level, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (pick(sel) === level) ok = 1'b1;
        end
    endtask

    // TX-engine model: consumes one TLP worth of data when it acknowledges.
    task automatic peer_tlp(input int dly, output bit ok);
        bit a, b;
        wait_level(0, 1'b1, 60, a);
        repeat (dly) tick();
        rd_ptr = rd_ptr + 11'd16;
        trigger_tlp_ack = 1'b1;
        wait_level(0, 1'b0, 20, b);
        trigger_tlp_ack = 1'b0;
        ok = a & b;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0) begin
            errors++; $display("FAIL reset_req: trig=%b chg=%b last=%b expected 0 0 0", trigger_tlp, change_huge_page, send_last);
        end
        checks++;
        if (qwords_to_send !== 5'd16) begin
            errors++; $display("FAIL reset_qwords: got %0d expected 16", qwords_to_send);
        end
        checks++;
        if (page_qword_offset !== 9'd16) begin
            errors++; $display("FAIL reset_offset: got %0d expected 16", page_qword_offset);
        end
        checks++;
        if (tlp_count !== 32'd0 || page_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: tlp=%0d page=%0d expected 0 0", tlp_count, page_count);
        end
        enable  = 1'b1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_tlps();
        bit ok;
        wr_ptr = 11'd48;
        tick(); tick();
        checks++;
        if (trigger_tlp !== 1'b0) begin
            errors++; $display("FAIL trig_early: got %b expected 0", trigger_tlp);
        end
        tick();
        checks++;
        if (trigger_tlp !== 1'b1) begin
            errors++; $display("FAIL trig_latency: got %b expected 1", trigger_tlp);
        end
        checks++;
        if (qwords_to_send !== 5'd16) begin
            errors++; $display("FAIL full_qwords: got %0d expected 16", qwords_to_send);
        end
        repeat (5) tick();
        rd_ptr = rd_ptr + 11'd16;
        trigger_tlp_ack = 1'b1;
        tick(); tick();
        checks++;
        if (trigger_tlp !== 1'b1) begin
            errors++; $display("FAIL ack_drop_early: got %b expected 1", trigger_tlp);
        end
        tick();
        checks++;
        if (trigger_tlp !== 1'b0) begin
            errors++; $display("FAIL ack_drop_latency: got %b expected 0", trigger_tlp);
        end
        trigger_tlp_ack = 1'b0;
        peer_tlp(5, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL full_tlp2: handshake ok=%b expected 1", ok);
        end
        peer_tlp(5, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL full_tlp3: handshake ok=%b expected 1", ok);
        end
        repeat (20) tick();
        checks++;
        if (tlp_count !== 32'd3 || page_qword_offset !== 9'd64 || trigger_tlp !== 1'b0) begin
            errors++; $display("FAIL full_result: tlp=%0d off=%0d trig=%b expected 3 64 0", tlp_count, page_qword_offset, trigger_tlp);
        end
    endtask

    task automatic test_timeout_flush();
        bit ok;
        timeout_cycles = 28'd100;
        wr_ptr = 11'd68;
        peer_tlp(5, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL flush_tlp: handshake ok=%b expected 1", ok);
        end
        repeat (10) tick();
        checks++;
        if (tlp_count !== 32'd4 || page_qword_offset !== 9'd80) begin
            errors++; $display("FAIL flush_pre: tlp=%0d off=%0d expected 4 80", tlp_count, page_qword_offset);
        end
        repeat (50) tick();
        checks++;
        if (send_last !== 1'b0 || change_huge_page !== 1'b0) begin
            errors++; $display("FAIL flush_early: last=%b chg=%b expected 0 0", send_last, change_huge_page);
        end
        wait_level(2, 1'b1, 200, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL flush_timeout: send_last seen=%b expected 1", ok);
        end
        checks++;
        if (qwords_to_send !== 5'd4 || change_huge_page !== 1'b0) begin
            errors++; $display("FAIL flush_qwords: qw=%0d chg=%b expected 4 0", qwords_to_send, change_huge_page);
        end
        repeat (3) tick();
        rd_ptr = rd_ptr + 11'd4;
        change_huge_page_ack = 1'b1;
        wait_level(2, 1'b0, 20, ok);
        change_huge_page_ack = 1'b0;
        timeout_cycles = '0;
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL flush_ack: send_last dropped=%b expected 1", ok);
        end
        repeat (10) tick();
        checks++;
        if (page_qword_offset !== 9'd16 || page_count !== 32'd1) begin
            errors++; $display("FAIL flush_result: off=%0d pages=%0d expected 16 1", page_qword_offset, page_count);
        end
    endtask

    task automatic test_page_change();
        bit ok;
        int fails = 0;
        wr_ptr = wr_ptr + 11'd224;
        for (int i = 0; i < 14; i++) begin
            peer_tlp(2, ok);
            if (ok !== 1'b1) fails++;
        end
        checks++;
        if (fails != 0) begin
            errors++; $display("FAIL fill_page: failed handshakes=%0d expected 0", fails);
        end
        repeat (10) tick();
        checks++;
        if (page_qword_offset !== 9'd240 || tlp_count !== 32'd18) begin
            errors++; $display("FAIL fill_result: off=%0d tlp=%0d expected 240 18", page_qword_offset, tlp_count);
        end
        wr_ptr = wr_ptr + 11'd32;
        wait_level(1, 1'b1, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL page_change: change seen=%b expected 1", ok);
        end
        checks++;
        if (trigger_tlp !== 1'b0 || send_last !== 1'b0) begin
            errors++; $display("FAIL page_change_excl: trig=%b last=%b expected 0 0", trigger_tlp, send_last);
        end
        change_huge_page_ack = 1'b1;
        wait_level(1, 1'b0, 20, ok);
        change_huge_page_ack = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL page_change_ack: change dropped=%b expected 1", ok);
        end
        fails = 0;
        for (int i = 0; i < 2; i++) begin
            peer_tlp(3, ok);
            if (ok !== 1'b1) fails++;
        end
        repeat (10) tick();
        checks++;
        if (fails != 0 || page_qword_offset !== 9'd48 || page_count !== 32'd2 || tlp_count !== 32'd20) begin
            errors++; $display("FAIL page_after: fails=%0d off=%0d pages=%0d tlp=%0d expected 0 48 2 20", fails, page_qword_offset, page_count, tlp_count);
        end
    endtask

    task automatic test_no_timeout();
        bit ok;
        int busy = 0;
        timeout_cycles = '0;
        wr_ptr = wr_ptr + 11'd5;
        repeat (10000) begin
            tick();
            if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0) busy++;
        end
        checks++;
        if (busy != 0) begin
            errors++; $display("FAIL timeout_disabled: request cycles=%0d expected 0", busy);
        end
        wr_ptr = wr_ptr + 11'd11;
        peer_tlp(2, ok);
        repeat (10) tick();
        checks++;
        if (ok !== 1'b1 || tlp_count !== 32'd21 || page_qword_offset !== 9'd64) begin
            errors++; $display("FAIL topup_tlp: ok=%b tlp=%0d off=%0d expected 1 21 64", ok, tlp_count, page_qword_offset);
        end
    endtask

    task automatic test_ack_hold_enable();
        bit ok;
        int bad = 0;
        wr_ptr = wr_ptr + 11'd32;
        wait_level(0, 1'b1, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL hold_first: trigger seen=%b expected 1", ok);
        end
        enable = 1'b0;
        rd_ptr = rd_ptr + 11'd16;
        trigger_tlp_ack = 1'b1;
        wait_level(0, 1'b0, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL hold_drop: trigger dropped=%b expected 1", ok);
        end
        repeat (20) begin
            tick();
            if (trigger_tlp !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_wait: trigger high cycles=%0d expected 0", bad);
        end
        trigger_tlp_ack = 1'b0;
        wait_level(0, 1'b1, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL hold_second: trigger seen=%b expected 1", ok);
        end
        rd_ptr = rd_ptr + 11'd16;
        trigger_tlp_ack = 1'b1;
        wait_level(0, 1'b0, 20, ok);
        trigger_tlp_ack = 1'b0;
        wr_ptr = wr_ptr + 11'd16;
        bad = 0;
        repeat (50) begin
            tick();
            if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0) bad++;
        end
        checks++;
        if (ok !== 1'b1 || bad != 0) begin
            errors++; $display("FAIL disabled_idle: ok=%b request cycles=%0d expected 1 0", ok, bad);
        end
        checks++;
        if (tlp_count !== 32'd23 || page_qword_offset !== 9'd96) begin
            errors++; $display("FAIL hold_result: tlp=%0d off=%0d expected 23 96", tlp_count, page_qword_offset);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad = 0;
        enable = 1'b1;
        wait_level(0, 1'b1, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL mid_req: trigger seen=%b expected 1", ok);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0) begin
            errors++; $display("FAIL mid_reset_req: trig=%b chg=%b last=%b expected 0 0 0", trigger_tlp, change_huge_page, send_last);
        end
        checks++;
        if (tlp_count !== 32'd0 || page_count !== 32'd0) begin
            errors++; $display("FAIL mid_reset_cnt: tlp=%0d pages=%0d expected 0 0", tlp_count, page_count);
        end
        checks++;
        if (page_qword_offset !== 9'd16 || qwords_to_send !== 5'd16) begin
            errors++; $display("FAIL mid_reset_regs: off=%0d qw=%0d expected 16 16", page_qword_offset, qwords_to_send);
        end
        wr_ptr = '0;
        rd_ptr = '0;
        tick(); tick();
        reset_n = 1'b1;
        repeat (20) begin
            tick();
            if (trigger_tlp !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL post_reset_idle: trigger high cycles=%0d expected 0", bad);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_tlps();
        test_timeout_flush();
        test_page_change();
        test_no_timeout();
        test_ack_hold_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_tlp_scheduler.md
# rx_tlp_scheduler

Parametrised successor of the RX TLP trigger. It runs in the 156.25 MHz domain and watches the RX internal buffer (write pointer local, read pointer from the 250 MHz TX-TLP engine). It decides when to request full-payload TLPs, partial flush TLPs and huge-page changes. It adds proper 2-flop CDC, a 4-phase request/ack handshake, a runtime timeout with disable, and statistics counters.

## Interface
- ADDR_W, 11, buffer pointer width in QWs; usable occupancy is ADDR_W-1 bits.
- TLP_QW, 16, max payload per TLP in QWs; power of 2, at least 2.
- PAGE_LOG2, 18, huge page size = 2^PAGE_LOG2 QWs.
- PAGE_HDR_QW, 16, reserved QWs at the start of each page.
- TO_W, 28, timeout counter width.
- clk156 in 1: clock.
- reset_n in 1: reset, asynchronous, active-low.
- enable in 1: when 0, no new transfers start; an in-flight sequence completes.
- timeout_cycles in TO_W: idle cycles before a flush; 0 disables the timeout.
- commited_wr_address in ADDR_W: clk156-domain write pointer.
- commited_rd_address_gray in ADDR_W: 250 MHz-domain read pointer, Gray coded.
- trigger_tlp out 1: level request for one TLP.
- trigger_tlp_ack in 1: 250 MHz ack, 4-phase.
- change_huge_page out 1: request to close the page with no partial data.
- send_last_tlp_change_huge_page out 1: request to send a partial TLP, then close the page.
- change_huge_page_ack in 1: 250 MHz ack, 4-phase; acknowledges either close request.
- qwords_to_send out log2(TLP_QW)+1: payload size for the current request.
- page_qword_offset out PAGE_LOG2+1: QWs committed to the current page.
- tlp_count out 32: full TLPs acknowledged, wraps.
- page_count out 32: pages closed, wraps.

## Operation
- rd pointer: Gray value passes through 2 flops, then Gray→binary. Both acks pass through 2 flops.
- occ: registered each cycle as (wr − rd_bin) mod 2^ADDR_W; only occ[ADDR_W-2:0] is used.
- Timeout counter:
  - Increments only in IDLE and clears in every other state.
  - Pulses timeout for one cycle when the counter equals timeout_cycles (≠0), then clears.
- IDLE:
  - Latches n_tlp = occ/TLP_QW, rem_new = occ%TLP_QW, look = offset + occ.
  - If enable and occ ≥ TLP_QW → CHECK, with qwords_to_send = TLP_QW.
  - Else if enable, timeout and dirty → CLOSE.
  - Else if enable, timeout and occ > 0 → FLUSH, with qwords_to_send = occ.
- CHECK:
  - If look[PAGE_LOG2] is set (overflow): rem == 0 → CHANGE; rem ≠ 0 → FLUSH with qwords_to_send = rem.
  - Otherwise: rem ← rem_new, dirty ← 1, sent ← 0, trigger_tlp ← 1 → REQ.
- REQ: on synced ack = 1, trigger_tlp ← 0, offset += TLP_QW, sent++, tlp_count++ → ACK_LOW.
- ACK_LOW: on synced ack = 0, go back to REQ with trigger_tlp ← 1 if sent < n_tlp, else → IDLE.
- CLOSE: rem == 0 → CHANGE; else FLUSH with qwords_to_send = rem.
- FLUSH: send_last_tlp_change_huge_page ← 1 → CHG_WAIT.
- CHANGE: change_huge_page ← 1 → CHG_WAIT.
- CHG_WAIT: on synced chg ack = 1, clear both close requests, offset ← PAGE_HDR_QW, rem ← 0, dirty ← 0, page_count++ → CHG_LOW.
- CHG_LOW: on synced chg ack = 0 → IDLE.
- Acks arriving while no request is pending are ignored.
- Unreachable state codes go to IDLE.

## Timing
- Reset values:
  - All outputs 0, except page_qword_offset = PAGE_HDR_QW and qwords_to_send = TLP_QW.
  - State IDLE; sync flops, occ, rem, dirty and the counters are all 0.
- Write-pointer change to IDLE decision: 1 cycle (occ register). Read-pointer change: 3 cycles (2 sync + occ).
- IDLE → first trigger_tlp = 1: 2 cycles (IDLE, CHECK).
- Ack edge → request drop: 3 cycles (2 sync + register).
- qwords_to_send is stable while any request is high.
- Reset mid-operation: all requests drop asynchronously. The peer must tolerate an abandoned handshake.
- Simultaneous timeout and occ ≥ TLP_QW: full-TLP path wins.

## Structure
- Shared package rx_tlp_pkg holds:
  - State enum (IDLE, CHECK, REQ, ACK_LOW, CLOSE, FLUSH, CHANGE, CHG_WAIT, CHG_LOW).
  - A clog2-based width function.
  - Default parameter constants.
- One sub-module, cdc_sync_2ff (parametrised width, async active-low reset), instanced for the rd pointer and for each ack.
- Gray→binary conversion is a package function.

## Test plan
- Write pointer +48, read pointer 0, acks after 5 cycles → three trigger_tlp pulses, each waits for ack low; offset 16→64; tlp_count = 3.
- Write pointer +20 → one TLP; rem = 4 is held. After timeout_cycles = 100 idle cycles → FLUSH with qwords_to_send = 4 and send_last high; after chg ack, offset = 16, page_count = 1.
- PAGE_LOG2 = 8, offset 240, occ 32 → no trigger; change_huge_page = 1; after ack, offset = 16, then 2 TLPs are sent.
- timeout_cycles = 0 with occ = 5 held for 10^4 cycles → no request issued.
- Ack held high across the ACK_LOW entry → next trigger waits until ack is low; enable = 0 mid-sequence → sequence completes, then stays IDLE.
- reset_n asserted in REQ → trigger_tlp is 0 immediately and all counters clear.
